contador_regressivo_mmss: RTL and testbench
===========================================

Name: contador_regressivo_mmss

Overview:
- Countdown timer, the down-counting counterpart of the up-counting mod-10 digit counters in the clock chain.
- Holds MM:SS as four BCD digits and decrements once per one-second tick, borrowing digit to digit.
- Emits a one-cycle end pulse at 00:00.
- Sits between the 1 Hz prescaler (`tick` source) and the 7-segment decoders (digit outputs).

Parameters:
- MIN_DEZ_MAX, 5, maximum legal minutes-tens digit; presets above it are clamped to it.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle enable pulse, one per second
- load  in  1  capture preset_min/preset_seg and go to IDLE
- preset_min  in  8  BCD minutes {tens[7:4], units[3:0]}
- preset_seg  in  8  BCD seconds {tens[7:4], units[3:0]}
- start  in  1  start or resume countdown
- pause  in  1  freeze countdown
- min_dez  out  4  minutes tens digit
- min_un  out  4  minutes units digit
- seg_dez  out  4  seconds tens digit
- seg_un  out  4  seconds units digit
- estado  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
- rodando  out  1  high when estado==RUN
- fim  out  1  one-cycle pulse on reaching 00:00

Behaviour:
- One clock `clk`; reset is synchronous and active-high on `reset`.
- Reset: all digits 0, stored preset 00:00, estado=IDLE, rodando=0, fim=0.
- Per-cycle priority: reset > load > start > pause > tick.
- Load, any state:
  - Next cycle, the digits and stored preset take the clamped preset; estado=IDLE.
  - Clamp: any units digit >9 becomes 9; seg tens >5 becomes 5; min tens >MIN_DEZ_MAX becomes MIN_DEZ_MAX.
- IDLE:
  - start with a nonzero value: RUN.
  - start at 00:00: ignored, stays IDLE.
  - tick and pause: ignored.
- RUN:
  - tick: decrement by one second.
  - pause: PAUSE; a tick in the same cycle is discarded.
  - start: ignored.
- PAUSE: digits frozen; ticks ignored; start returns to RUN; pause ignored.
- DONE: digits hold 00:00; tick, start and pause ignored; only load or reset leave DONE.
- Start cycle: a tick coinciding with start is not applied; the first decrement is on the next tick.
- Decrement chain, all registered in the cycle after tick:
  - seg_un: 0 becomes 9 with borrow, else -1.
  - seg_dez, on borrow: 0 becomes 5 with borrow, else -1.
  - min_un, on borrow: 0 becomes 9 with borrow, else -1.
  - min_dez, on borrow: -1.
- Reaching 00:00: on the RUN tick that takes the value from 00:01 to 00:00:
  - Next cycle: digits=00:00, estado=DONE, fim=1.
  - fim returns to 0 the following cycle.
- Latency: tick to updated digits is 1 cycle. fim is registered, coincident with the 00:00 digits.
- Max value 59:59 with default parameter; no wrap below 00:00.
- Reset mid-countdown: returns to the reset values above next cycle; no fim pulse.

Optional Feature:
- Macro AUTO_RELOAD_EN.
- Defined:
  - On reaching 00:00, estado stays RUN (not DONE) and fim pulses as above.
  - The next tick reloads the stored preset instead of decrementing; countdown continues. Period = preset + 1 ticks.
  - Stored preset 00:00 behaves as without the macro (goes to DONE).
  - pause/start work normally.
- Undefined: DONE behaviour as described in Behaviour.

Test Plan:
- Reset then load preset_min=8'h01, preset_seg=8'h00, start, 1 tick → 00:59, estado=RUN.
- Load 00:03, start, 3 ticks → 00:02, 00:01, 00:00; fim high exactly 1 cycle with estado=DONE; further ticks keep 00:00, fim=0.
- Load 10:00, start, tick → 09:59 (full borrow chain); load 8'hFF/8'hFF → clamped 59:59 (MIN_DEZ_MAX=5).
- RUN at 00:10, pause with simultaneous tick → still 00:10, PAUSE; 5 ticks → unchanged; start then tick → 00:09.
- Start at 00:00 in IDLE → stays IDLE; reset asserted mid-RUN at 02:30 → next cycle 00:00, IDLE, fim=0.
- AUTO_RELOAD_EN defined, load 00:02, start, 4 ticks → 00:01, 00:00 (fim pulse), 00:02, 00:01; estado=RUN throughout.

Source files
------------

// File: rtl/contador_regressivo_mmss.sv
`default_nettype none
// ============================================================================
// Module      : contador_regressivo_mmss
// Description : MM:SS countdown timer kept as four BCD digits. It decrements
//               once per one-second tick, borrowing from digit to digit, and
//               emits a one-cycle end pulse on reaching 00:00.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   tick       in   one-cycle enable pulse, one per second
//   load       in   capture preset_min/preset_seg (clamped), go to IDLE
//   preset_min in   BCD minutes {tens, units}
//   preset_seg in   BCD seconds {tens, units}
//   start      in   start or resume the countdown
//   pause      in   freeze the countdown
//   min_dez    out  minutes tens digit
//   min_un     out  minutes units digit
//   seg_dez    out  seconds tens digit
//   seg_un     out  seconds units digit
//   estado     out  IDLE=00, RUN=01, PAUSE=10, DONE=11
//   rodando    out  high while estado==RUN
//   fim        out  one-cycle pulse, coincident with the 00:00 digits
// Parameters:
//   MIN_DEZ_MAX  maximum legal minutes-tens digit (presets are clamped)
// Build option:
//   AUTO_RELOAD_EN  when defined, reaching 00:00 keeps RUN and the next tick
//                   reloads the stored preset (a 00:00 preset still ends in DONE)
// ============================================================================
module contador_regressivo_mmss #(
  parameter int unsigned MIN_DEZ_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_seg,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_dez,
  output logic [3:0] min_un,
  output logic [3:0] seg_dez,
  output logic [3:0] seg_un,
  output logic [1:0] estado,
  output logic       rodando,
  output logic       fim
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [3:0] c_min_dez_max = 4'(MIN_DEZ_MAX);

  // Time is held as {min_dez, min_un, seg_dez, seg_un}.
  state_t      r_state;
  state_t      w_state_n;
  logic [15:0] r_time;
  logic [15:0] w_time_n;
  logic        r_fim;
  logic        w_fim_n;

  // Preset clamping
  logic [3:0]  w_ld_mdez, w_ld_mun, w_ld_sdez, w_ld_sun;
  logic [15:0] w_clamped;

  assign w_ld_mdez = (preset_min[7:4] > c_min_dez_max) ? c_min_dez_max : preset_min[7:4];
  assign w_ld_mun  = (preset_min[3:0] > 4'd9) ? 4'd9 : preset_min[3:0];
  assign w_ld_sdez = (preset_seg[7:4] > 4'd5) ? 4'd5 : preset_seg[7:4];
  assign w_ld_sun  = (preset_seg[3:0] > 4'd9) ? 4'd9 : preset_seg[3:0];
  assign w_clamped = {w_ld_mdez, w_ld_mun, w_ld_sdez, w_ld_sun};

  // Borrow chain: each digit only moves when every lower digit wraps.
  logic       w_b0, w_b1, w_b2;
  logic [3:0] w_dec_mdez, w_dec_mun, w_dec_sdez, w_dec_sun;
  logic [15:0] w_dec;

  assign w_b0 = (r_time[3:0] == 4'd0);
  assign w_b1 = w_b0 && (r_time[7:4] == 4'd0);
  assign w_b2 = w_b1 && (r_time[11:8] == 4'd0);

  assign w_dec_sun  = w_b0 ? 4'd9 : r_time[3:0] - 4'd1;
  assign w_dec_sdez = !w_b0 ? r_time[7:4] :
                      ((r_time[7:4] == 4'd0) ? 4'd5 : r_time[7:4] - 4'd1);
  assign w_dec_mun  = !w_b1 ? r_time[11:8] :
                      ((r_time[11:8] == 4'd0) ? 4'd9 : r_time[11:8] - 4'd1);
  assign w_dec_mdez = w_b2 ? r_time[15:12] - 4'd1 : r_time[15:12];
  assign w_dec      = {w_dec_mdez, w_dec_mun, w_dec_sdez, w_dec_sun};

  logic w_zero, w_one;
  assign w_zero = (r_time == 16'h0000);
  assign w_one  = (r_time == 16'h0001);

`ifdef AUTO_RELOAD_EN
  logic [15:0] r_preset;
  logic [15:0] w_preset_n;
`endif

  always_comb begin
    w_state_n = r_state;
    w_time_n  = r_time;
    w_fim_n   = 1'b0;
`ifdef AUTO_RELOAD_EN
    w_preset_n = r_preset;
`endif
    if (load) begin
      w_time_n  = w_clamped;
      w_state_n = IDLE;
`ifdef AUTO_RELOAD_EN
      w_preset_n = w_clamped;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !w_zero) w_state_n = RUN;
        end
        RUN: begin
          // Start is meaningless while running; pause wins over a same-cycle tick.
          if (pause) begin
            w_state_n = PAUSE;
          end else if (tick) begin
`ifdef AUTO_RELOAD_EN
            if (w_zero) begin
              // Only reachable after an auto-reload 00:00; restart the period.
              w_time_n = r_preset;
            end else begin
              w_time_n = w_dec;
              if (w_one) begin
                w_fim_n = 1'b1;
                if (r_preset == 16'h0000) w_state_n = DONE;
              end
            end
`else
            w_time_n = w_dec;
            if (w_one) begin
              w_fim_n   = 1'b1;
              w_state_n = DONE;
            end
`endif
          end
        end
        PAUSE: begin
          // A tick in the resume cycle is dropped: start outranks tick.
          if (start) w_state_n = RUN;
        end
        DONE: begin
          w_state_n = DONE;
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_time  <= 16'h0000;
      r_fim   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      r_preset <= 16'h0000;
`endif
    end else begin
      r_state <= w_state_n;
      r_time  <= w_time_n;
      r_fim   <= w_fim_n;
`ifdef AUTO_RELOAD_EN
      r_preset <= w_preset_n;
`endif
    end
  end

  assign min_dez = r_time[15:12];
  assign min_un  = r_time[11:8];
  assign seg_dez = r_time[7:4];
  assign seg_un  = r_time[3:0];
  assign estado  = r_state;
  assign rodando = (r_state == RUN);
  assign fim     = r_fim;

endmodule
`default_nettype wire

// File: tb/tb_contador_regressivo_mmss.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_regressivo_mmss
// Description : Self-checking bench for contador_regressivo_mmss. A reference
//               model keeps the time as a plain count of seconds and derives
//               the expected digits by division; directed steps are followed
//               by a randomized input sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_regressivo_mmss;

  localparam int c_min_dez_max = 5;
`ifdef AUTO_RELOAD_EN
  localparam bit c_auto = 1'b1;
`else
  localparam bit c_auto = 1'b0;
`endif
  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset, tick, load, start, pause;
  logic [7:0] preset_min, preset_seg;
  logic [3:0] min_dez, min_un, seg_dez, seg_un;
  logic [1:0] estado;
  logic       rodando, fim;

  contador_regressivo_mmss #(.MIN_DEZ_MAX(c_min_dez_max)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .preset_min (preset_min),
    .preset_seg (preset_seg),
    .start      (start),
    .pause      (pause),
    .min_dez    (min_dez),
    .min_un     (min_un),
    .seg_dez    (seg_dez),
    .seg_un     (seg_un),
    .estado     (estado),
    .rodando    (rodando),
    .fim        (fim)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: time in seconds, stored preset in seconds.
  int   m_secs   = 0;
  int   m_preset = 0;
  int   m_st     = ST_IDLE;
  logic m_fim    = 1'b0;

  function automatic int clamp_secs(input logic [7:0] pm, input logic [7:0] ps);
    int md, mu, sd, su;
    md = int'(pm[7:4]);
    mu = int'(pm[3:0]);
    sd = int'(ps[7:4]);
    su = int'(ps[3:0]);
    if (md > c_min_dez_max) md = c_min_dez_max;
    if (mu > 9) mu = 9;
    if (sd > 5) sd = 5;
    if (su > 9) su = 9;
    return (md * 10 + mu) * 60 + sd * 10 + su;
  endfunction

  function automatic logic [15:0] to_digits(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_step();
    if (reset) begin
      m_secs = 0; m_preset = 0; m_st = ST_IDLE; m_fim = 1'b0;
    end else begin
      m_fim = 1'b0;
      if (load) begin
        m_secs   = clamp_secs(preset_min, preset_seg);
        m_preset = m_secs;
        m_st     = ST_IDLE;
      end else begin
        case (m_st)
          ST_IDLE:  if (start && m_secs != 0) m_st = ST_RUN;
          ST_RUN: begin
            if (pause) m_st = ST_PAUSE;
            else if (tick) begin
              if (m_secs == 0) m_secs = m_preset;
              else begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                  m_fim = 1'b1;
                  if (!(c_auto && m_preset != 0)) m_st = ST_DONE;
                end
              end
            end
          end
          ST_PAUSE: if (start) m_st = ST_RUN;
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(input string tag);
    logic [15:0] got_d, exp_d;
    got_d = {min_dez, min_un, seg_dez, seg_un};
    exp_d = to_digits(m_secs);
    total++;
    assert (got_d === exp_d) else begin
      bad++; $error("FAIL %s digits got=%h exp=%h", tag, got_d, exp_d);
    end
    total++;
    assert (estado === 2'(m_st)) else begin
      bad++; $error("FAIL %s estado got=%0d exp=%0d", tag, estado, m_st);
    end
    total++;
    assert (rodando === (m_st == ST_RUN)) else begin
      bad++; $error("FAIL %s rodando got=%b exp=%b", tag, rodando, (m_st == ST_RUN));
    end
    total++;
    assert (fim === m_fim) else begin
      bad++; $error("FAIL %s fim got=%b exp=%b", tag, fim, m_fim);
    end
  endtask

  // Fixed expectations taken straight from the scenario, independent of the model.
  task automatic expect_const(input string tag, input logic [15:0] d,
                              input logic [1:0] e, input logic f);
    logic [15:0] got_d;
    got_d = {min_dez, min_un, seg_dez, seg_un};
    total++;
    assert (got_d === d) else begin
      bad++; $error("FAIL %s const digits got=%h exp=%h", tag, got_d, d);
    end
    total++;
    assert (estado === e) else begin
      bad++; $error("FAIL %s const estado got=%0d exp=%0d", tag, estado, e);
    end
    total++;
    assert (fim === f) else begin
      bad++; $error("FAIL %s const fim got=%b exp=%b", tag, fim, f);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [7:0] pm,
                      input logic [7:0] ps, input logic s, input logic p,
                      input logic t, input string tag);
    reset = r; load = l; preset_min = pm; preset_seg = ps;
    start = s; pause = p; tick = t;
    @(posedge clk);
    model_step();
    #1;
    check(tag);
  endtask

  initial begin
    logic r, l, s, p, t;
    logic [7:0] pm, ps;
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    preset_min = 8'h00; preset_seg = 8'h00;

    // Reset state
    step(1, 0, 8'h00, 8'h00, 0, 0, 0, "reset");
    expect_const("reset", 16'h0000, 2'b00, 1'b0);

    // 01:00 -> 00:59
    step(0, 1, 8'h01, 8'h00, 0, 0, 0, "load_0100");
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, "start_0100");
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "tick_0100");
    expect_const("tick_0100", 16'h0059, 2'b01, 1'b0);

    // 00:03 down to 00:00
    step(0, 1, 8'h00, 8'h03, 0, 0, 0, "load_0003");
    step(0, 0, 8'h00, 8'h00, 1, 0, 1, "start_tick_0003");
    expect_const("start_tick_0003", 16'h0003, 2'b01, 1'b0);
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "t1_0003");
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "t2_0003");
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "t3_0003");
`ifdef AUTO_RELOAD_EN
    expect_const("t3_0003", 16'h0000, 2'b01, 1'b1);
`else
    expect_const("t3_0003", 16'h0000, 2'b11, 1'b1);
`endif
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, "after_fim");
    step(0, 0, 8'h00, 8'h00, 1, 1, 1, "done_hold");
`ifndef AUTO_RELOAD_EN
    expect_const("done_hold", 16'h0000, 2'b11, 1'b0);
`endif

    // Full borrow chain and clamping
    step(0, 1, 8'h10, 8'h00, 0, 0, 0, "load_1000");
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, "start_1000");
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "tick_1000");
    expect_const("tick_1000", 16'h0959, 2'b01, 1'b0);
    step(0, 1, 8'hFF, 8'hFF, 0, 0, 0, "load_ffff");
    expect_const("load_ffff", 16'h5959, 2'b00, 1'b0);

    // Pause with coincident tick, frozen ticks, resume
    step(0, 1, 8'h00, 8'h10, 0, 0, 0, "load_0010");
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, "start_0010");
    step(0, 0, 8'h00, 8'h00, 0, 1, 1, "pause_tick");
    expect_const("pause_tick", 16'h0010, 2'b10, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 1, "paused_tick");
    expect_const("paused_5", 16'h0010, 2'b10, 1'b0);
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, "resume");
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "resume_tick");
    expect_const("resume_tick", 16'h0009, 2'b01, 1'b0);

    // Start at 00:00 is ignored; reset mid-run
    step(0, 1, 8'h00, 8'h00, 0, 0, 0, "load_0000");
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, "start_zero");
    expect_const("start_zero", 16'h0000, 2'b00, 1'b0);
    step(0, 1, 8'h02, 8'h30, 0, 0, 0, "load_0230");
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, "start_0230");
    step(1, 0, 8'h00, 8'h00, 0, 0, 1, "reset_run");
    expect_const("reset_run", 16'h0000, 2'b00, 1'b0);

`ifdef AUTO_RELOAD_EN
    step(0, 1, 8'h00, 8'h02, 0, 0, 0, "ar_load");
    step(0, 0, 8'h00, 8'h00, 1, 0, 0, "ar_start");
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "ar_t1");
    expect_const("ar_t1", 16'h0001, 2'b01, 1'b0);
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "ar_t2");
    expect_const("ar_t2", 16'h0000, 2'b01, 1'b1);
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "ar_t3");
    expect_const("ar_t3", 16'h0002, 2'b01, 1'b0);
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "ar_t4");
    expect_const("ar_t4", 16'h0001, 2'b01, 1'b0);
`endif

    // Randomized traffic, small presets so 00:00 is reached often
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom % 300) == 0;
      l  = ($urandom % 40) == 0;
      pm = (($urandom % 8) == 0) ? 8'($urandom) : 8'h00;
      ps = (($urandom % 4) == 0) ? 8'($urandom)
                                 : {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      s  = (($urandom % 8) == 0) && (m_st != ST_RUN);
      p  = ($urandom % 16) == 0;
      t  = ($urandom % 2) == 0;
      step(r, l, pm, ps, s, p, t, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
